memory: RTL and testbench

Pipeline MEM stage of the single-issue CPU: sits between `execute` and `writeback` and acts as the producer of the `mem_done`/`data_mem`/`rd` handshake that `writeback` consumes. The stage accepts one operation from `execute`, performs the load or store against the word-wide `ram`, then presents the result to `writeback` for one cycle. Sub-word stores are read-modify-write, because `ram` has a single word write enable.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 67 ++++++
 rtl/memory.sv | 175 +++++++++++++++++
 tb/tb_memory.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: funct3 access codes, size fields,
// MEM stage state encoding and the latched memory-op bundle.
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_DONE  = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic        load;
        logic        store;
        logic        regwrite;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
    } mem_op_t;

endpackage

// File: rtl/lsu_align.sv
// Load lane select/extension and sub-word store merge.
// Sizes 1x behave as word; funct3[2] selects zero-extension.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        byte_v = rdata[7:0];
        unique case (addr_lo)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sext = ~funct3[2];
    end

    always_comb begin
        load_data = rdata;
        unique case (1'b1)
            funct3[1:0] == SZ_B:
                load_data = {{24{sext & byte_v[7]}}, byte_v};
            funct3[1:0] == SZ_H:
                load_data = {{16{sext & half_v[15]}}, half_v};
            default:
                load_data = rdata;
        endcase
    end

    always_comb begin
        store_word = sdata;
        unique case (1'b1)
            funct3[1:0] == SZ_B: begin
                store_word = rdata;
                unique case (addr_lo)
                    2'd0: store_word[7:0]   = sdata[7:0];
                    2'd1: store_word[15:8]  = sdata[7:0];
                    2'd2: store_word[23:16] = sdata[7:0];
                    2'd3: store_word[31:24] = sdata[7:0];
                    default: store_word = rdata;
                endcase
            end
            funct3[1:0] == SZ_H: begin
                if (addr_lo[1])
                    store_word = {sdata[15:0], rdata[15:0]};
                else
                    store_word = {rdata[31:16], sdata[15:0]};
            end
            default:
                store_word = sdata;
        endcase
    end

endmodule

// File: rtl/memory.sv
// MEM pipeline stage: loads, stores and sub-word RMW on a word RAM.
// Optional MEM_MISALIGN_TRAP_EN adds the misaligned output/trap.
module memory
    import cpu_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        ready,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic        in_RegWrite,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    output logic        ram_write_enable,
    input  logic [31:0] ram_data_out,
    output logic        mem_done,
    output logic [31:0] data_out,
    output logic [31:0] result_alu,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);

    mem_state_t  state;
    mem_op_t     op;
    mem_op_t     in_op;
    mem_op_t     cur;
    logic [CW-1:0] cnt;

    logic        is_mem;
    logic        is_word;
    logic        is_half;
    logic        trap;
    logic        go_done;
    logic        go_write;
    logic        go_read;
    logic        rd_last;
    logic        accept;
    logic        enter_done;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    always_comb begin
        in_op.load     = in_MemRead & ~in_MemWrite;
        in_op.store    = in_MemWrite;
        in_op.regwrite = in_RegWrite;
        in_op.funct3   = in_funct3;
        in_op.addr     = in_result;
        in_op.sdata    = in_store_data;
        in_op.rd       = in_rd;
    end

    // Decode from live inputs while idle, from the latched op afterwards.
    assign cur = (state == MEM_IDLE) ? in_op : op;

    assign is_mem  = cur.load | cur.store;
    assign is_word = cur.funct3[1];
    assign is_half = (cur.funct3[1:0] == SZ_H);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem &
                  ((is_half & cur.addr[0]) |
                   (is_word & (cur.addr[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    assign go_done  = trap | ~is_mem;
    assign go_write = ~trap & cur.store & is_word;
    assign go_read  = ~trap & (cur.load | (cur.store & ~is_word));

    assign rd_last = (cnt == CNT_LAST);
    assign accept  = (state == MEM_IDLE) & in_valid;

    assign enter_done = (accept & go_done) |
                        ((state == MEM_READ) & rd_last & cur.load) |
                        (state == MEM_WRITE);

    lsu_align u_align (
        .funct3     (cur.funct3),
        .addr_lo    (cur.addr[1:0]),
        .rdata      (ram_data_out),
        .sdata      (cur.sdata),
        .load_data  (ld_data),
        .store_word (st_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= MEM_IDLE;
            op               <= '0;
            cnt              <= '0;
            ready            <= 1'b1;
            ram_address      <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
            mem_done         <= 1'b0;
            data_out         <= '0;
            result_alu       <= '0;
            rd_out           <= '0;
            RegWrite_out     <= 1'b0;
            MemToReg_out     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned       <= 1'b0;
`endif
        end else begin
            mem_done         <= 1'b0;
            ram_write_enable <= 1'b0;
            unique case (state)
                MEM_IDLE: begin
                    if (in_valid) begin
                        op    <= in_op;
                        cnt   <= '0;
                        ready <= 1'b0;
                        if (go_read | go_write)
                            ram_address <= {in_result[31:2], 2'b00};
                        unique case (1'b1)
                            go_done:  state <= MEM_DONE;
                            go_write: begin
                                state            <= MEM_WRITE;
                                ram_data_in      <= st_word;
                                ram_write_enable <= 1'b1;
                            end
                            go_read:  state <= MEM_READ;
                            default:  state <= MEM_DONE;
                        endcase
                    end
                end
                MEM_READ: begin
                    if (!rd_last) begin
                        cnt <= cnt + 1'b1;
                    end else if (op.load) begin
                        state <= MEM_DONE;
                    end else begin
                        state            <= MEM_WRITE;
                        ram_data_in      <= st_word;
                        ram_write_enable <= 1'b1;
                    end
                end
                MEM_WRITE: state <= MEM_DONE;
                MEM_DONE: begin
                    state <= MEM_IDLE;
                    ready <= 1'b1;
                end
                default: state <= MEM_IDLE;
            endcase
            if (enter_done) begin
                mem_done     <= 1'b1;
                data_out     <= (cur.load & ~trap) ? ld_data : 32'd0;
                result_alu   <= cur.addr;
                rd_out       <= cur.rd;
                RegWrite_out <= cur.regwrite & ~trap;
                MemToReg_out <= cur.load;
`ifdef MEM_MISALIGN_TRAP_EN
                misaligned   <= trap;
`endif
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for the MEM stage against a
// combinational-read word RAM model (READ_LATENCY = 1).
module tb_memory;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        ready;
    logic        in_MemRead;
    logic        in_MemWrite;
    logic        in_RegWrite;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic [31:0] ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write_enable;
    logic [31:0] ram_data_out;
    logic        mem_done;
    logic [31:0] data_out;
    logic [31:0] result_alu;
    logic [4:0]  rd_out;
    logic        RegWrite_out;
    logic        MemToReg_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    logic [31:0] ram [0:63];
    int          wr_count;
    logic [31:0] last_wdata;
    int          n_cmp;
    int          n_err;
    int          lat;
    int          w0;

    memory #(.READ_LATENCY(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .ready            (ready),
        .in_MemRead       (in_MemRead),
        .in_MemWrite      (in_MemWrite),
        .in_RegWrite      (in_RegWrite),
        .in_funct3        (in_funct3),
        .in_result        (in_result),
        .in_store_data    (in_store_data),
        .in_rd            (in_rd),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_data_out     (ram_data_out),
        .mem_done         (mem_done),
        .data_out         (data_out),
        .result_alu       (result_alu),
        .rd_out           (rd_out),
        .RegWrite_out     (RegWrite_out),
        .MemToReg_out     (MemToReg_out)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misaligned       (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_data_out = ram[ram_address[7:2]];

    always @(posedge clk) begin
        if (ram_write_enable) begin
            ram[ram_address[7:2]] <= ram_data_in;
            wr_count   <= wr_count + 1;
            last_wdata <= ram_data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!ready && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic do_op(input logic rd_i, input logic wr_i,
                         input logic rw_i, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, output int l);
        wait_ready();
        in_valid      = 1'b1;
        in_MemRead    = rd_i;
        in_MemWrite   = wr_i;
        in_RegWrite   = rw_i;
        in_funct3     = f3;
        in_result     = addr;
        in_store_data = sd;
        in_rd         = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        l = 1;
        while (!mem_done && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!mem_done) check("done_timeout", 32'(mem_done), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        wr_count = 0;
        last_wdata = '0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[4] = 32'h876543A1;
        in_valid = 0; in_MemRead = 0; in_MemWrite = 0; in_RegWrite = 0;
        in_funct3 = 0; in_result = 0; in_store_data = 0; in_rd = 0;

        rst = 1'b0;
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(mem_done), 32'd0);
        check("rst_we", 32'(ram_write_enable), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_addr", ram_address, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_misaligned", 32'(misaligned), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_op(1, 0, 1, 3'b000, 32'h13, 32'h0, 5'd7, lat);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_data", data_out, 32'hFFFFFF87);
        check("lb_rd", 32'(rd_out), 32'd7);
        check("lb_m2r", 32'(MemToReg_out), 32'd1);
        check("lb_rw", 32'(RegWrite_out), 32'd1);
        check("lb_alu", result_alu, 32'h13);

        do_op(1, 0, 1, 3'b101, 32'h12, 32'h0, 5'd1, lat);
        check("lhu_data", data_out, 32'h00008765);
        do_op(1, 0, 1, 3'b001, 32'h10, 32'h0, 5'd2, lat);
        check("lh_data", data_out, 32'h000043A1);
        do_op(1, 0, 1, 3'b100, 32'h10, 32'h0, 5'd3, lat);
        check("lbu_data", data_out, 32'h000000A1);

        w0 = wr_count;
        do_op(0, 1, 0, 3'b000, 32'h11, 32'h000000CC, 5'd0, lat);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_writes", 32'(wr_count - w0), 32'd1);
        check("sb_wdata", last_wdata, 32'h8765CCA1);
        check("sb_data_out", data_out, 32'd0);
        check("sb_m2r", 32'(MemToReg_out), 32'd0);

        do_op(1, 0, 1, 3'b010, 32'h10, 32'h0, 5'd4, lat);
        check("lw_data", data_out, 32'h8765CCA1);

        w0 = wr_count;
        do_op(0, 0, 1, 3'b000, 32'h42, 32'hDEAD, 5'd5, lat);
        check("alu_lat", 32'(lat), 32'd1);
        check("alu_ready_low", 32'(ready), 32'd0);
        check("alu_result", result_alu, 32'h42);
        check("alu_data_out", data_out, 32'd0);
        check("alu_rd", 32'(rd_out), 32'd5);
        check("alu_writes", 32'(wr_count - w0), 32'd0);

        do_op(0, 1, 0, 3'b010, 32'h20, 32'h11223344, 5'd0, lat);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_ram", ram[8], 32'h11223344);

        do_op(1, 1, 1, 3'b010, 32'h24, 32'h00000055, 5'd6, lat);
        check("rw_m2r", 32'(MemToReg_out), 32'd0);
        check("rw_ram", ram[9], 32'h00000055);

        do_op(1, 0, 1, 3'b011, 32'h20, 32'h0, 5'd8, lat);
        check("ld011_data", data_out, 32'h11223344);

        w0 = wr_count;
        do_op(1, 0, 1, 3'b010, 32'h12, 32'h0, 5'd9, lat);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_rw", 32'(RegWrite_out), 32'd0);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_writes", 32'(wr_count - w0), 32'd0);
`else
        check("lw12_data", data_out, 32'h8765CCA1);
        check("lw12_rw", 32'(RegWrite_out), 32'd1);
`endif

        wait_ready();
        w0 = wr_count;
        in_valid      = 1'b1;
        in_MemRead    = 1'b0;
        in_MemWrite   = 1'b1;
        in_RegWrite   = 1'b0;
        in_funct3     = 3'b000;
        in_result     = 32'h10;
        in_store_data = 32'h000000EE;
        in_rd         = 5'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rmw_we_high", 32'(ram_write_enable), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rmw_we_drop", 32'(ram_write_enable), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rmw_ready", 32'(ready), 32'd1);
        check("rmw_ram", ram[4], 32'h8765CCA1);
        check("rmw_writes", 32'(wr_count - w0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
